// File: rtl/faerie_uart.sv
// faerie_uart: memory-mapped 8N1 UART target on the CPU memory bus.
// Four byte registers at BASE..BASE+3 (DATA, STATUS, DIV_LO, DIV_HI). Loads
// return data one cycle after the strobe and 0 otherwise, so the bus can be
// OR-combined with other targets. Transmit side has a 4-entry FIFO feeding a
// shifter; receive side has a single holding register.
module faerie_uart #(
    parameter logic [15:0] BASE      = 16'hFF00,
    parameter logic [15:0] DIV_RESET = 16'd103
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] addr,
    input  logic [7:0]  wdata,
    input  logic        we,
    input  logic        re,
    output logic [7:0]  rdata,
    input  logic        rxd,
    output logic        txd
);

    typedef enum logic [1:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_STOP
    } tx_state_t;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP
    } rx_state_t;

    // ---------------- bus decode ----------------
    logic       sel;
    logic [1:0] off;
    logic       wr_acc;
    logic       rd_acc;
    logic       rd_data;
    logic       rd_status;

    assign sel       = (addr[15:2] == BASE[15:2]);
    assign off       = addr[1:0];
    assign wr_acc    = we && sel;
    // A simultaneous store wins: the load has no side effects and returns 0.
    assign rd_acc    = re && !we && sel;
    assign rd_data   = rd_acc && (off == 2'd0);
    assign rd_status = rd_acc && (off == 2'd1);

    // ---------------- baud divider ----------------
    logic [15:0] div_reg;
    logic [15:0] div_eff;

    // Divider values below 3 are clamped so half-bit timing stays meaningful.
    assign div_eff = (div_reg < 16'd3) ? 16'd3 : div_reg;

    // Divider register, byte-writable; FSMs pick it up at their next reload.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            div_reg <= DIV_RESET;
        end else if (wr_acc && off == 2'd2) begin
            div_reg[7:0] <= wdata;
        end else if (wr_acc && off == 2'd3) begin
            div_reg[15:8] <= wdata;
        end
    end

    // ---------------- TX FIFO ----------------
    logic [7:0] fifo_mem [4];
    logic [1:0] wptr;
    logic [1:0] rptr;
    logic [2:0] fifo_cnt;
    logic       fifo_full;
    logic       fifo_empty;
    logic       push;
    logic       pop;

    assign fifo_full  = (fifo_cnt == 3'd4);
    assign fifo_empty = (fifo_cnt == 3'd0);
    // Pushes into a full FIFO are dropped even if a pop happens the same cycle.
    assign push       = wr_acc && (off == 2'd0) && !fifo_full;

    // FIFO pointers and occupancy; push and pop may coincide.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wptr     <= 2'd0;
            rptr     <= 2'd0;
            fifo_cnt <= 3'd0;
        end else begin
            if (push) wptr <= wptr + 2'd1;
            if (pop)  rptr <= rptr + 2'd1;
            case ({push, pop})
                2'b10:   fifo_cnt <= fifo_cnt + 3'd1;
                2'b01:   fifo_cnt <= fifo_cnt - 3'd1;
                default: fifo_cnt <= fifo_cnt;
            endcase
        end
    end

    // FIFO storage; contents need no reset since occupancy is tracked above.
    always_ff @(posedge clk) begin
        if (push) fifo_mem[wptr] <= wdata;
    end

    // ---------------- TX FSM ----------------
    tx_state_t   tx_state;
    tx_state_t   tx_state_next;
    logic [15:0] tx_cnt;
    logic [15:0] tx_cnt_next;
    logic [2:0]  tx_bit;
    logic [2:0]  tx_bit_next;
    logic [7:0]  tx_shift;
    logic        tx_load;
    logic        tx_shift_en;
    logic        txd_next;
    logic        tx_empty;

    assign pop      = tx_load;
    assign tx_empty = fifo_empty && (tx_state == TX_IDLE);

    // TX next-state: each state holds DIV+1 clocks; txd is registered from the next state.
    always_comb begin
        tx_state_next = tx_state;
        tx_cnt_next   = tx_cnt;
        tx_bit_next   = tx_bit;
        tx_load       = 1'b0;
        tx_shift_en   = 1'b0;
        txd_next      = txd;
        if (tx_state != TX_IDLE && tx_cnt != 16'd0) begin
            tx_cnt_next = tx_cnt - 16'd1;
        end else begin
            case (tx_state)
                TX_IDLE: begin
                    if (!fifo_empty) begin
                        tx_state_next = TX_START;
                        tx_cnt_next   = div_eff;
                        tx_load       = 1'b1;
                        txd_next      = 1'b0;
                    end
                end
                TX_START: begin
                    tx_state_next = TX_DATA;
                    tx_cnt_next   = div_eff;
                    tx_bit_next   = 3'd0;
                    txd_next      = tx_shift[0];
                end
                TX_DATA: begin
                    tx_cnt_next = div_eff;
                    if (tx_bit == 3'd7) begin
                        tx_state_next = TX_STOP;
                        txd_next      = 1'b1;
                    end else begin
                        tx_bit_next = tx_bit + 3'd1;
                        tx_shift_en = 1'b1;
                        txd_next    = tx_shift[1];
                    end
                end
                TX_STOP: begin
                    // Chain straight into the next frame when more data is queued.
                    if (!fifo_empty) begin
                        tx_state_next = TX_START;
                        tx_cnt_next   = div_eff;
                        tx_load       = 1'b1;
                        txd_next      = 1'b0;
                    end else begin
                        tx_state_next = TX_IDLE;
                        txd_next      = 1'b1;
                    end
                end
                default: tx_state_next = TX_IDLE;
            endcase
        end
    end

    // TX control registers; reset forces the line idle-high immediately.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tx_state <= TX_IDLE;
            tx_cnt   <= 16'd0;
            tx_bit   <= 3'd0;
            txd      <= 1'b1;
        end else begin
            tx_state <= tx_state_next;
            tx_cnt   <= tx_cnt_next;
            tx_bit   <= tx_bit_next;
            txd      <= txd_next;
        end
    end

    // TX shifter: loaded from the FIFO head, shifted right LSB-first.
    always_ff @(posedge clk) begin
        if (tx_load) begin
            tx_shift <= fifo_mem[rptr];
        end else if (tx_shift_en) begin
            tx_shift <= {1'b0, tx_shift[7:1]};
        end
    end

    // ---------------- RX ----------------
    logic        rx_meta;
    logic        rx_sync;
    logic        rx_last;
    logic        rx_fall;
    rx_state_t   rx_state;
    rx_state_t   rx_state_next;
    logic [15:0] rx_cnt;
    logic [15:0] rx_cnt_next;
    logic [2:0]  rx_bit;
    logic [2:0]  rx_bit_next;
    logic [7:0]  rx_shift;
    logic [7:0]  rx_hold;
    logic [15:0] rx_half;
    logic        rx_shift_en;
    logic        rx_store;
    logic        set_overrun;
    logic        set_frame_err;
    logic        rx_valid;
    logic        rx_overrun;
    logic        rx_frame_err;

    assign rx_fall = rx_last && !rx_sync;
    // floor((DIV+1)/2) computed without widening: ceil(DIV/2).
    assign rx_half = {1'b0, div_eff[15:1]} + {15'd0, div_eff[0]};

    // Two-flop synchroniser plus one delayed copy for falling-edge detection.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
            rx_last <= 1'b1;
        end else begin
            rx_meta <= rxd;
            rx_sync <= rx_meta;
            rx_last <= rx_sync;
        end
    end

    // RX next-state: half-bit to mid-start, then full-bit samples of data and stop.
    always_comb begin
        rx_state_next = rx_state;
        rx_cnt_next   = rx_cnt;
        rx_bit_next   = rx_bit;
        rx_shift_en   = 1'b0;
        rx_store      = 1'b0;
        set_overrun   = 1'b0;
        set_frame_err = 1'b0;
        if (rx_state != RX_IDLE && rx_cnt != 16'd0) begin
            rx_cnt_next = rx_cnt - 16'd1;
        end else begin
            case (rx_state)
                RX_IDLE: begin
                    if (rx_fall) begin
                        rx_state_next = RX_START;
                        rx_cnt_next   = rx_half - 16'd1;
                    end
                end
                RX_START: begin
                    // Line back high at mid-start means a glitch, not a frame.
                    if (rx_sync) begin
                        rx_state_next = RX_IDLE;
                    end else begin
                        rx_state_next = RX_DATA;
                        rx_cnt_next   = div_eff;
                        rx_bit_next   = 3'd0;
                    end
                end
                RX_DATA: begin
                    rx_shift_en = 1'b1;
                    rx_cnt_next = div_eff;
                    if (rx_bit == 3'd7) begin
                        rx_state_next = RX_STOP;
                    end else begin
                        rx_bit_next = rx_bit + 3'd1;
                    end
                end
                RX_STOP: begin
                    rx_state_next = RX_IDLE;
                    if (!rx_sync) begin
                        set_frame_err = 1'b1;
                    end else if (rx_valid) begin
                        set_overrun = 1'b1;
                    end else begin
                        rx_store = 1'b1;
                    end
                end
                default: rx_state_next = RX_IDLE;
            endcase
        end
    end

    // RX control registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_state <= RX_IDLE;
            rx_cnt   <= 16'd0;
            rx_bit   <= 3'd0;
        end else begin
            rx_state <= rx_state_next;
            rx_cnt   <= rx_cnt_next;
            rx_bit   <= rx_bit_next;
        end
    end

    // RX data path: shift in LSB-first, copy to the holding register on a good stop.
    always_ff @(posedge clk) begin
        if (rx_shift_en) rx_shift <= {rx_sync, rx_shift[7:1]};
        if (rx_store)    rx_hold  <= rx_shift;
    end

    // Status flags: a set in the same cycle as a read-clear wins.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_valid     <= 1'b0;
            rx_overrun   <= 1'b0;
            rx_frame_err <= 1'b0;
        end else begin
            if (rx_store)       rx_valid <= 1'b1;
            else if (rd_data)   rx_valid <= 1'b0;
            if (set_overrun)    rx_overrun <= 1'b1;
            else if (rd_status) rx_overrun <= 1'b0;
            if (set_frame_err)  rx_frame_err <= 1'b1;
            else if (rd_status) rx_frame_err <= 1'b0;
        end
    end

    // ---------------- read data ----------------
    logic [7:0] status;

    assign status = {3'b000, rx_frame_err, rx_overrun, rx_valid, tx_empty, fifo_full};

    // Registered load data, held for exactly one cycle and 0 otherwise.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rdata <= 8'h00;
        end else if (rd_acc) begin
            case (off)
                2'd0:    rdata <= rx_hold;
                2'd1:    rdata <= status;
                2'd2:    rdata <= div_reg[7:0];
                default: rdata <= div_reg[15:8];
            endcase
        end else begin
            rdata <= 8'h00;
        end
    end

endmodule

// File: doc/faerie_uart.md
# faerie_uart

Memory-mapped UART target for Faerie's CPU memory bus: it answers the loads and stores issued by the control unit and converts them to a serial 8N1 link. Placement is alongside RAM on the shared bus. Reads have a fixed 1-cycle latency, which matches the CPU's synchronous-read timing. The block contains a 4-entry TX FIFO, a single RX holding register, a status register and a programmable baud divider.

## Interface
- `BASE`, default 16'hFF00: base address; the block decodes `BASE`..`BASE+3`.
- `DIV_RESET`, default 16'd103: reset value of the baud divider. Bit period is DIV+1 clocks.
- `clk`  in  1  CPU clock; all state changes on the rising edge.
- `rst`  in  1  reset; asynchronous, active-low.
- `addr`  in  16  bus address, valid in the cycle `we`/`re` is high.
- `wdata`  in  8  store data.
- `we`  in  1  store strobe; one cycle per access.
- `re`  in  1  load strobe; one cycle per access.
- `rdata`  out  8  load data, registered; driven the cycle after `re`; 0 otherwise.
- `rxd`  in  1  serial input, asynchronous to `clk`.
- `txd`  out  1  serial output; idle high.

## Operation
- Address decode: `sel = addr[15:2] == BASE[15:2]`. Offset `addr[1:0]` selects the register:
  - 0 DATA: a write pushes to the TX FIFO; a read returns the RX holding byte and clears `rx_valid`.
  - 1 STATUS (read-only), bits:
    - [0] tx_full
    - [1] tx_empty (FIFO empty and shifter idle)
    - [2] rx_valid
    - [3] rx_overrun
    - [4] rx_frame_err
    - [7:5] 0
  - 2 DIV_LO: read/write.
  - 3 DIV_HI: read/write.
- Unselected accesses are ignored, and `rdata` is 0 the next cycle so the bus can be OR-combined.
- If `we` and `re` are both high in the same cycle, the write is performed, the read has no side effects, and `rdata` is 0.
- TX FIFO: depth 4, 2-bit pointers plus a count.
  - A push when full is dropped silently; FIFO contents are unchanged.
  - A push and a pop (shifter load) in the same cycle are both performed.
- TX FSM: IDLE -> START -> DATA(8 bits, LSB first) -> STOP -> IDLE, or directly STOP -> START if the FIFO is non-empty.
  - The FSM loads its shifter from the FIFO head in the cycle it leaves IDLE/STOP.
  - Each state lasts DIV+1 clocks, counted by a down-counter reloaded at each bit boundary.
- RX: `rxd` passes through a 2-flop synchroniser. RX FSM: IDLE -> START -> DATA -> STOP.
  - In IDLE, a synchronised falling edge starts the half-bit counter, floor((DIV+1)/2).
  - At mid-start, if the line is high, the frame is discarded and the FSM returns to IDLE as a false start.
  - It then samples 8 bits at full-bit intervals, then the stop bit.
- RX stop bit low: the byte is discarded and `rx_frame_err` is set.
- RX stop bit high with `rx_valid` = 0: the byte is loaded into the holding register and `rx_valid` is set.
- RX stop bit high with `rx_valid` = 1: the old byte is kept and `rx_overrun` is set.
- A STATUS read clears `rx_overrun` and `rx_frame_err`; the returned value is the pre-clear value.
  - If a set and a clear occur in the same cycle, set wins.
- Divider:
  - Effective DIV = max(DIV, 3).
  - A write takes effect at the next bit-counter reload of each FSM. Frames already in flight are not restarted.
- Reset (`rst` low, at any time, including mid-frame): both FSMs go to IDLE and the FIFO is emptied. Output and register values are given under Timing.

## Timing
- Reset values:
  - `txd` = 1, `rdata` = 0.
  - DIV = `DIV_RESET`.
  - STATUS = 8'h02 (tx_empty).
- Read latency is exactly 1 cycle. `rdata` is captured on the edge where `re` is sampled and held for one cycle, then returns to 0.
- Read side effects (RX clear, flag clear) take effect on that same edge.
- Write side effects are visible in the next cycle:
  - STATUS read 1 cycle after a DATA write reflects the push.
  - tx_empty falls on the edge that samples the write.
- TX start: `txd` falls 1 cycle after a push into an empty, idle transmitter.
- Frame length is 10×(DIV+1) clocks. Back-to-back FIFO bytes have no idle gap.
- RX decision delay: the sampled byte is available 2 cycles (synchroniser) + 9.5 bit periods after the start edge on `rxd`, ±1 clock.

## Test plan
- Reset with `rst` low for 3 cycles: `txd` = 1. Read at `BASE+1` returns 8'h02, and at `BASE+2` returns 8'd103.
- Write DIV = 4 (LO = 4, HI = 0), then write 8'hA5 to DATA: `txd` low 1 cycle later. Each bit lasts 5 clocks with pattern 1,0,1,0,0,1,0,1 (LSB first), then a stop bit. tx_empty returns to 1 after 50 clocks.
- Write 6 bytes 8'h01..8'h06 back to back with DIV = 4:
  - tx_full = 1 after the 5th write (4 queued + 1 in the shifter).
  - The 6th byte is dropped.
  - Exactly 5 contiguous frames are output.
- Drive `rxd` with 8'h3C at DIV = 7: STATUS bit2 = 1, and a DATA read returns 8'h3C one cycle after `re`. A following STATUS read returns bit2 = 0.
- Send two RX frames without reading: the 2nd sets rx_overrun and DATA still returns the first byte. Send a frame with the stop bit low: rx_frame_err = 1. A STATUS read clears both flags.
- Assert `rst` mid-TX frame: `txd` = 1 immediately (asynchronous), the FIFO is empty, and STATUS = 8'h02 after release. Reads at `BASE+4` return 0.
